// File: rtl/acl2_spi_target_emulator.sv
// ADXL362-style SPI mode-0 register target for the PMOD ACL2 connector.
// Optional interrupt pins are built when ACL2_TGT_INT_EN is defined.
module acl2_spi_target_emulator #(
    parameter int parm_sck_ratio_min = 8,
    parameter int parm_addr_bits     = 6
) (
    input  logic                      i_clk_20mhz,
    input  logic                      i_rst_20mhz_n,
    input  logic                      ei_sck,
    input  logic                      ei_csn,
    input  logic                      ei_copi,
    output logic                      eo_cipo_o,
    output logic                      eo_cipo_t,
    input  logic [63:0]               i_meas_data,
    input  logic                      i_meas_valid,
    output logic                      o_wr_strobe,
    output logic [parm_addr_bits-1:0] o_wr_addr,
    output logic [7:0]                o_wr_data,
    output logic [7:0]                o_reg_power_ctl,
    output logic [7:0]                o_err_count,
    output logic                      eo_int1,
    output logic                      eo_int2
);
    localparam int AW = parm_addr_bits;
    localparam int NREG = 1 << AW;
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam int STATUS = 11;
    localparam int SOFT_RST = 31;
    localparam int POWER_CTL = 45;
    // Below this ratio the synchronizer delay eats the SCK half-period.
    localparam bit RATIO_OK = (parm_sck_ratio_min >= 8);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_WRITE, ST_READ, ST_IGNORE
    } state_t;

    function automatic logic [7:0] reg_default(input int a);
        case (a)
            0:       return 8'hAD;
            1:       return 8'h1D;
            2:       return 8'hF2;
            3:       return 8'h01;
            44:      return 8'h13;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic is_meas(input logic [AW-1:0] a);
        int v = int'(a);
        return (v >= 14) && (v <= 21);
    endfunction

    function automatic logic is_ro(input logic [AW-1:0] a);
        int v = int'(a);
        return (v <= 3) || (v == STATUS) || is_meas(a);
    endfunction

    logic [2:0]    sck_sync_q, csn_sync_q;
    logic [1:0]    copi_sync_q;
    state_t        state_q, state_d;
    logic          rd_q, rd_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shin_q, shin_d;
    logic [7:0]    shout_q, shout_d;
    logic [AW-1:0] addr_q, addr_d, addr_nxt;
    logic          cipo_o_q, cipo_o_d;
    logic          cipo_t_q, cipo_t_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    err_q, err_d;
    logic          soft_rst_q, soft_rst_d;
    logic [7:0]    regs_q [NREG];
    logic [7:0]    regs_d [NREG];

    logic sck_rise, sck_fall, csn_s, csn_fall, copi_s, byte_done;
    logic [7:0] byte_in;

    assign sck_rise  = RATIO_OK && sck_sync_q[1] && !sck_sync_q[2];
    assign sck_fall  = RATIO_OK && !sck_sync_q[1] && sck_sync_q[2];
    assign csn_s     = csn_sync_q[1];
    assign csn_fall  = !csn_sync_q[1] && csn_sync_q[2];
    assign copi_s    = copi_sync_q[1];
    assign byte_in   = {shin_q[6:0], copi_s};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    assign addr_nxt  = addr_q + ADDR_ONE;

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        bit_cnt_d   = bit_cnt_q;
        shin_d      = shin_q;
        shout_d     = shout_q;
        addr_d      = addr_q;
        cipo_o_d    = cipo_o_q;
        cipo_t_d    = csn_s;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;
        soft_rst_d  = 1'b0;
        regs_d      = regs_q;
        if (soft_rst_q) begin
            for (int i = 0; i < NREG; i++) regs_d[i] = reg_default(i);
        end
        if (csn_s) begin
            state_d  = ST_IDLE;
            cipo_o_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (csn_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                        shout_d   = '0;
                    end
                end
                default: begin
                    if (sck_rise) begin
                        shin_d    = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (sck_fall) begin
                        cipo_o_d = (state_q == ST_READ) && shout_q[7];
                        shout_d  = {shout_q[6:0], 1'b0};
                    end
                    if (byte_done) begin
                        case (state_q)
                            ST_CMD: begin
                                if (byte_in == 8'h0A || byte_in == 8'h0B) begin
                                    rd_d    = byte_in[0];
                                    state_d = ST_ADDR;
                                end else begin
                                    state_d = ST_IGNORE;
                                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                                end
                            end
                            ST_ADDR: begin
                                addr_d  = byte_in[AW-1:0];
                                state_d = rd_q ? ST_READ : ST_WRITE;
                                if (rd_q) shout_d = regs_q[byte_in[AW-1:0]];
                            end
                            ST_WRITE: begin
                                if (!is_ro(addr_q)) regs_d[addr_q] = byte_in;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = addr_q;
                                wr_data_d   = byte_in;
                                soft_rst_d  = (int'(addr_q) == SOFT_RST) &&
                                              (byte_in == 8'h52);
                                addr_d      = addr_nxt;
                            end
                            ST_READ: begin
                                if (is_meas(addr_q)) regs_d[STATUS][0] = 1'b0;
                                addr_d  = addr_nxt;
                                shout_d = regs_q[addr_nxt];
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
        // Applied last so a new sample beats a same-cycle DATA_READY clear.
        if (i_meas_valid) begin
            for (int k = 0; k < 8; k++) regs_d[14 + k] = i_meas_data[63 - 8*k -: 8];
            regs_d[STATUS][0] = 1'b1;
        end
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (!i_rst_20mhz_n) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '1;
            copi_sync_q <= '0;
            state_q     <= ST_IDLE;
            rd_q        <= 1'b0;
            bit_cnt_q   <= '0;
            shin_q      <= '0;
            shout_q     <= '0;
            addr_q      <= '0;
            cipo_o_q    <= 1'b0;
            cipo_t_q    <= 1'b1;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= '0;
            soft_rst_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= reg_default(i);
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], ei_sck};
            csn_sync_q  <= {csn_sync_q[1:0], ei_csn};
            copi_sync_q <= {copi_sync_q[0], ei_copi};
            state_q     <= state_d;
            rd_q        <= rd_d;
            bit_cnt_q   <= bit_cnt_d;
            shin_q      <= shin_d;
            shout_q     <= shout_d;
            addr_q      <= addr_d;
            cipo_o_q    <= cipo_o_d;
            cipo_t_q    <= cipo_t_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
            soft_rst_q  <= soft_rst_d;
            regs_q      <= regs_d;
        end
    end

    assign eo_cipo_o       = cipo_o_q;
    assign eo_cipo_t       = cipo_t_q;
    assign o_wr_strobe     = wr_strobe_q;
    assign o_wr_addr       = wr_addr_q;
    assign o_wr_data       = wr_data_q;
    assign o_reg_power_ctl = regs_q[POWER_CTL];
    assign o_err_count     = err_q;

`ifdef ACL2_TGT_INT_EN
    logic int1_q, int1_d, int2_q, int2_d;

    // Bit 7 of each INTMAP selects an active-low pin.
    always_comb begin
        int1_d = (regs_q[STATUS][0] & regs_q[42][0]) ^ regs_q[42][7];
        int2_d = (regs_q[STATUS][0] & regs_q[43][0]) ^ regs_q[43][7];
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (!i_rst_20mhz_n) begin
            int1_q <= 1'b0;
            int2_q <= 1'b0;
        end else begin
            int1_q <= int1_d;
            int2_q <= int2_d;
        end
    end

    assign eo_int1 = int1_q;
    assign eo_int2 = int2_q;
`else
    assign eo_int1 = 1'b0;
    assign eo_int2 = 1'b0;
`endif
endmodule

// File: tb/tb_acl2_spi_target_emulator.sv
// Randomized bench for acl2_spi_target_emulator against a
// transaction-level register-map model.
module tb_acl2_spi_target_emulator;
    logic        clk = 1'b0;
    logic        rst_n, sck, csn, copi, meas_valid;
    logic [63:0] meas_data;
    logic        cipo_o, cipo_t, wr_strobe, int1, int2;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data, power_ctl, err_count;

    int total = 0;
    int bad = 0;
    int strobe_cnt = 0;
    logic [7:0] m_regs [64];
    int m_err = 0;

    acl2_spi_target_emulator u_dut (
        .i_clk_20mhz    (clk),
        .i_rst_20mhz_n  (rst_n),
        .ei_sck         (sck),
        .ei_csn         (csn),
        .ei_copi        (copi),
        .eo_cipo_o      (cipo_o),
        .eo_cipo_t      (cipo_t),
        .i_meas_data    (meas_data),
        .i_meas_valid   (meas_valid),
        .o_wr_strobe    (wr_strobe),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data),
        .o_reg_power_ctl(power_ctl),
        .o_err_count    (err_count),
        .eo_int1        (int1),
        .eo_int2        (int2)
    );

    always #25 clk = ~clk;

    always @(posedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

    initial begin
        #(50 * 90000);
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_defaults();
        for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
        m_regs[0] = 8'hAD; m_regs[1] = 8'h1D; m_regs[2] = 8'hF2;
        m_regs[3] = 8'h01; m_regs[44] = 8'h13;
    endtask

    function automatic bit m_meas(input int a);
        return a >= 14 && a <= 21;
    endfunction

    function automatic bit m_ro(input int a);
        return a <= 3 || a == 11 || m_meas(a);
    endfunction

    function automatic logic m_int(input int map_addr);
`ifdef ACL2_TGT_INT_EN
        return (m_regs[11][0] & m_regs[map_addr][0]) ^ m_regs[map_addr][7];
`else
        return 1'b0;
`endif
    endfunction

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nb; i--) begin
            copi = tx[i];
            tick(4);
            rx[i] = cipo_o;
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_begin();
        csn = 1'b0;
        tick(4);
        chk("cipo_t_active", cipo_t, 1'b0);
    endtask

    task automatic cs_end();
        tick(4);
        csn = 1'b1;
        tick(6);
        chk("cipo_t_idle", cipo_t, 1'b1);
    endtask

    task automatic check_side();
        chk("power_ctl", power_ctl, m_regs[45]);
        chk("err_count", err_count, m_err);
        chk("int1", int1, m_int(42));
        chk("int2", int2, m_int(43));
    endtask

    task automatic spi_write(input int a, input logic [31:0] d, input int n);
        logic [7:0] rx, b;
        int s0, ma, la;
        logic [7:0] ld;
        s0 = strobe_cnt;
        cs_begin();
        xfer(8'h0A, rx);
        xfer(8'(a), rx);
        for (int k = 0; k < n; k++) xfer(d[31 - 8*k -: 8], rx);
        cs_end();
        ma = a & 63; la = 0; ld = 8'h00;
        for (int k = 0; k < n; k++) begin
            b = d[31 - 8*k -: 8];
            if (!m_ro(ma)) m_regs[ma] = b;
            if (ma == 31 && b == 8'h52) m_defaults();
            la = ma; ld = b;
            ma = (ma + 1) & 63;
        end
        chk("wr_strobes", strobe_cnt - s0, n);
        chk("wr_addr", wr_addr, la);
        chk("wr_data", wr_data, ld);
        check_side();
    endtask

    task automatic spi_read(input int a, input int n, output logic [63:0] got);
        logic [7:0] rx;
        int ma;
        got = '0;
        ma = a & 63;
        cs_begin();
        xfer(8'h0B, rx);
        xfer(8'(a), rx);
        for (int k = 0; k < n; k++) begin
            xfer(8'h00, rx);
            chk("rd_byte", rx, m_regs[ma]);
            got = {got[55:0], rx};
            if (m_meas(ma)) m_regs[11][0] = 1'b0;
            ma = (ma + 1) & 63;
        end
        cs_end();
        check_side();
    endtask

    task automatic meas_load(input logic [63:0] d);
        meas_data = d;
        meas_valid = 1'b1;
        tick(1);
        meas_valid = 1'b0;
        tick(2);
        for (int k = 0; k < 8; k++) m_regs[14 + k] = d[63 - 8*k -: 8];
        m_regs[11][0] = 1'b1;
        check_side();
    endtask

    task automatic bad_cmd(input logic [7:0] cmd);
        logic [7:0] rx;
        cs_begin();
        xfer(cmd, rx);
        xfer(8'hFF, rx);
        cs_end();
        if (m_err < 255) m_err++;
        chk("ignore_cipo", rx, 8'h00);
        check_side();
    endtask

    initial begin
        logic [63:0] got;
        logic [7:0]  rx, cmd;
        int s0, a, n;
        rst_n = 1'b0; sck = 1'b0; csn = 1'b1; copi = 1'b0;
        meas_valid = 1'b0; meas_data = '0;
        m_defaults();
        tick(5);
        rst_n = 1'b1;
        tick(2);
        chk("rst_cipo_o", cipo_o, 1'b0);
        chk("rst_cipo_t", cipo_t, 1'b1);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_wr_addr", wr_addr, 6'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_power", power_ctl, 8'h00);
        chk("rst_err", err_count, 8'h00);
        chk("rst_int1", int1, 1'b0);
        chk("rst_int2", int2, 1'b0);

        spi_read(0, 4, got);
        chk("id_burst", got[31:0], 32'hAD1DF201);

        spi_write(8'h2D, 32'h02000000, 1);
        chk("power_after_wr", power_ctl, 8'h02);
        spi_read(8'h2D, 1, got);
        chk("power_readback", got[7:0], 8'h02);

        meas_load(64'h0102030405060708);
        spi_read(8'h0B, 1, got);
        chk("status_set", got[7:0], 8'h01);
        spi_read(8'h0E, 8, got);
        chk("meas_bytes", got, 64'h0102030405060708);
        spi_read(8'h0B, 1, got);
        chk("status_clr", got[7:0], 8'h00);

        spi_write(8'h3F, 32'h11220000, 2);
        spi_read(8'h3F, 2, got);
        chk("wrap_3f", got[15:8], 8'h11);
        chk("ro_00", got[7:0], 8'hAD);

        bad_cmd(8'h0D);
        chk("err_one", err_count, 8'h01);

        s0 = strobe_cnt;
        cs_begin();
        xfer(8'h0A, rx);
        xfer(8'h30, rx);
        spi_bits(8'hAA, 5, rx);
        cs_end();
        chk("abort_no_strobe", strobe_cnt - s0, 0);
        spi_read(8'h30, 1, got);
        chk("abort_no_write", got[7:0], 8'h00);

        spi_write(8'h2D, 32'h02000000, 1);
        spi_write(8'h1F, 32'h52000000, 1);
        chk("soft_rst_power", power_ctl, 8'h00);

        spi_write(8'h2A, 32'h01000000, 1);
        meas_load(64'hA1A2A3A4A5A6A7A8);
`ifdef ACL2_TGT_INT_EN
        chk("int1_hi", int1, 1'b1);
`endif
        spi_read(8'h0E, 1, got);
        chk("int1_idle_low", int1, 1'b0);
        spi_write(8'h2A, 32'h81000000, 1);
        meas_load(64'hB1B2B3B4B5B6B7B8);
`ifdef ACL2_TGT_INT_EN
        chk("int1_act_low", int1, 1'b0);
`endif
        spi_read(8'h0E, 1, got);

        repeat (40) begin
            case ($urandom_range(0, 4))
                0: begin
                    a = $urandom_range(0, 63);
                    n = $urandom_range(1, 3);
                    if ($urandom_range(0, 7) == 0) spi_write(8'h1F, 32'h52000000 | ($urandom & 32'h00FFFFFF), n);
                    else spi_write(a, $urandom, n);
                end
                1, 2: spi_read($urandom_range(0, 63), $urandom_range(1, 4), got);
                3: meas_load({$urandom, $urandom});
                default: begin
                    cmd = 8'($urandom);
                    if (cmd == 8'h0A || cmd == 8'h0B) cmd = 8'h3C;
                    bad_cmd(cmd);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
